dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data path width; only 32 is supported.
REQ-002 Parameter DEPTH_WORDS, default 1024, memory depth in 32-bit words; a power of two.
REQ-003 Parameter LATENCY, default 2, cycles from request accept to response; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  DATA_WIDTH  byte address.
REQ-010 req_wdata  input  DATA_WIDTH  store data, right-aligned.
REQ-011 req_funct3  input  3  RV32I load/store funct3.
REQ-012 rsp_valid  output  1  single-cycle response pulse.
REQ-013 rsp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  request rejected, qualified by rsp_valid.

Function
REQ-015 FSM states: IDLE, BUSY, RESP. The FSM SHALL move IDLE->BUSY on accept, BUSY->RESP when the latency counter expires, and RESP->IDLE unconditionally.
REQ-016 Accept SHALL occur when req_valid=1 and req_ready=1. req_ready SHALL be 1 only in IDLE.
REQ-017 On accept, the block SHALL latch we, addr, wdata and funct3, and SHALL ignore later changes on the req_* inputs.
REQ-018 rsp_valid SHALL be 1 exactly LATENCY cycles after the accept cycle, for exactly one cycle (the RESP state).
REQ-019 For LATENCY=1, the FSM SHALL go IDLE->RESP directly, skipping BUSY.
REQ-020 Throughput SHALL be one request per LATENCY+1 cycles. There is no back-pressure on the response, so the requester shall always take it.
REQ-021 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]. Upper address bits SHALL be ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-022 Byte lanes SHALL be little-endian: byte k of a word is at addr[1:0]=k.
REQ-023 Store funct3 decoding:
- 0 (SB) writes one lane from wdata[7:0];
- 1 (SH) writes lanes {addr[1],0} and {addr[1],1} from wdata[15:0];
- 2 (SW) writes all four lanes.
Unselected lanes SHALL remain unchanged.
REQ-024 Load funct3 decoding:
- 0 = LB, sign-extended;
- 1 = LH, sign-extended;
- 2 = LW;
- 4 = LBU, zero-extended;
- 5 = LHU, zero-extended.
REQ-025 Error conditions: halfword access with addr[0]=1; word access with addr[1:0]!=0; load funct3 in {3,6,7}; store funct3 >2. On error, rsp_err=1, rsp_rdata=0, and no memory write occurs.
REQ-026 Memory update for a store, and the read sample for a load, SHALL both happen on the clock edge entering RESP.
REQ-027 A load accepted after a store completes SHALL return the stored data; no stale read is permitted.
REQ-028 rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid=0.

Reset
REQ-029 While rst=1, the FSM SHALL be IDLE, the counter 0, req_ready=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0. req_ready SHALL become 1 in the first cycle after rst deasserts.
REQ-030 Reset asserted in BUSY SHALL abort the operation: no memory write, no response.
REQ-031 Memory contents SHALL NOT be cleared by rst. Initial contents are undefined unless preloaded by the bench.
REQ-032 A request presented while rst=1 SHALL NOT be accepted.

Verification
REQ-033 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_valid exactly 2 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-034 After REQ-033: SB addr 0x11 data 0x80, then LB 0x11 -> rdata 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
REQ-035 SH addr 0x22 data 0x1234 over word 0xAAAAAAAA, then LH 0x22 -> 0x00001234; LW 0x20 -> 0x1234AAAA.
REQ-036 LW 0x13 -> rsp_err=1, rdata 0. Then LW 0x10 -> unchanged data, proving no side effect. Repeat with SH 0x21 and store funct3=3 -> err=1, memory unchanged.
REQ-037 With DEPTH_WORDS=1024: SW 0x1000 data 0x55 -> LW 0x0 returns 0x55 (wrap). Hold req_valid=1 continuously -> accepts spaced exactly LATENCY+1 cycles apart.
REQ-038 Accept SW 0x40 data 0x1, assert rst the next cycle -> no rsp_valid; after reset, LW 0x40 returns the previous contents. Also run REQ-033 with LATENCY=1 -> response 1 cycle after accept.

Source files
------------

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for RV32I loads/stores.
// One request in flight; response pulses LATENCY cycles after accept.
module dmem_responder #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned IW = AW + 2;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_INIT = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [IW-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  ready_q, ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  logic                  cur_we;
  logic [IW-1:0]         cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [2:0]            cur_funct3;
  logic [1:0]            lane;
  logic [AW-1:0]         idx;
  logic [DATA_WIDTH-1:0] word, wr_word, lane_data, load_data;
  logic [3:0]            be;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic                  op_err, mem_we, accept;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^req_addr[DATA_WIDTH-1:IW];

  // With LATENCY=1 the RESP edge is the accept edge, so use the live request
  always_comb begin
    cur_we     = (state_q == IDLE) ? req_we            : we_q;
    cur_addr   = (state_q == IDLE) ? req_addr[IW-1:0]  : addr_q;
    cur_wdata  = (state_q == IDLE) ? req_wdata         : wdata_q;
    cur_funct3 = (state_q == IDLE) ? req_funct3        : funct3_q;
  end

  assign lane = cur_addr[1:0];
  assign idx  = cur_addr[IW-1:2];
  assign word = mem_q[idx];

  always_comb begin
    op_err    = 1'b0;
    be        = 4'b0000;
    lane_data = cur_wdata;
    if (cur_we) begin
      op_err = (cur_funct3 > 3'd2) || (cur_funct3 == 3'd1 && lane[0]) ||
               (cur_funct3 == 3'd2 && lane != 2'd0);
      case (cur_funct3)
        3'd0: begin be = 4'b0001 << lane; lane_data = {4{cur_wdata[7:0]}}; end
        3'd1: begin be = lane[1] ? 4'b1100 : 4'b0011; lane_data = {2{cur_wdata[15:0]}}; end
        3'd2: be = 4'b1111;
        default: be = 4'b0000;
      endcase
    end else begin
      case (cur_funct3)
        3'd0, 3'd4: op_err = 1'b0;
        3'd1, 3'd5: op_err = lane[0];
        3'd2:       op_err = (lane != 2'd0);
        default:    op_err = 1'b1;
      endcase
    end
    wr_word = word;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) wr_word[8*k +: 8] = lane_data[8*k +: 8];
    end
  end

  // Load extraction, little-endian lanes
  always_comb begin
    ld_byte = word[{lane, 3'b000} +: 8];
    ld_half = lane[1] ? word[31:16] : word[15:0];
    case (cur_funct3)
      3'd0:    load_data = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    load_data = {{16{ld_half[15]}}, ld_half};
      3'd2:    load_data = word;
      3'd4:    load_data = {24'd0, ld_byte};
      3'd5:    load_data = {16'd0, ld_half};
      default: load_data = '0;
    endcase
  end

  assign accept = req_valid && ready_q && (state_q == IDLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = (LATENCY == 1) ? RESP : BUSY;
          cnt_d    = CNT_INIT;
          we_d     = req_we;
          addr_d   = req_addr[IW-1:0];
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d     = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    rsp_err_d   = (state_d == RESP) && op_err;
    rsp_rdata_d = (state_d == RESP && !cur_we && !op_err) ? load_data : '0;
    mem_we      = !rst && (state_d == RESP) && cur_we && !op_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      funct3_q    <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= wr_word;
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
